// File: rtl/nav_keypad_if.sv
// Button/move signal bundle between the raw keypad inputs and the cursor stage.
interface nav_keypad_if;
  logic btn_left;
  logic btn_right;
  logic btn_up;
  logic btn_down;
  logic move_left;
  logic move_right;
  logic move_up;
  logic move_down;
  logic held;

  modport master (
    output btn_left, btn_right, btn_up, btn_down,
    input  move_left, move_right, move_up, move_down, held
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down,
    output move_left, move_right, move_up, move_down, held
  );
endinterface

// File: rtl/nav_keypad.sv
// Four-button navigation keypad: sync, debounce, priority accept, move pulses.
// Define NAV_AUTOREPEAT_EN for auto-repeat; otherwise one pulse per press.
module nav_keypad #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic         clk,
  input  logic         reset,
  nav_keypad_if.slave  kp
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, WAIT_REL} state_e;

  localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES - 1);

  // Bit order throughout: 0 left, 1 right, 2 up, 3 down.
  logic [3:0]  btn_raw;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [19:0] db_cnt_q [4];
  logic [19:0] db_cnt_d [4];
  logic [3:0]  db_lvl_q, db_lvl_d;
  state_e      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [3:0]  move_q, move_d;
`ifdef NAV_AUTOREPEAT_EN
  localparam logic [25:0] RD_MAX = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0] RP_MAX = 26'(REPEAT_PERIOD - 1);
  logic [25:0] timer_q, timer_d;
`endif

  assign btn_raw = {kp.btn_down, kp.btn_up, kp.btn_right, kp.btn_left};

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    for (int unsigned i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) db_lvl_d[i] = ~db_lvl_q[i];
        else                       db_cnt_d[i] = db_cnt_q[i] + 20'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    move_d  = '0;
`ifdef NAV_AUTOREPEAT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (|db_lvl_q) begin
          if      (db_lvl_q[0]) dir_d = 2'd0;
          else if (db_lvl_q[1]) dir_d = 2'd1;
          else if (db_lvl_q[2]) dir_d = 2'd2;
          else                  dir_d = 2'd3;
          move_d[dir_d] = 1'b1;
`ifdef NAV_AUTOREPEAT_EN
          timer_d = RD_MAX;
          state_d = DELAY;
`else
          state_d = WAIT_REL;
`endif
        end
      end
`ifdef NAV_AUTOREPEAT_EN
      // Release is checked first so it wins over a timer-zero pulse.
      DELAY, REPEAT: begin
        if (!db_lvl_q[dir_q]) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          move_d[dir_q] = 1'b1;
          timer_d       = RP_MAX;
          state_d       = REPEAT;
        end else begin
          timer_d = timer_q - 26'd1;
        end
      end
`endif
      WAIT_REL: begin
        if (!db_lvl_q[dir_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_lvl_q <= '0;
      state_q  <= IDLE;
      dir_q    <= '0;
      move_q   <= '0;
`ifdef NAV_AUTOREPEAT_EN
      timer_q  <= '0;
`endif
      for (int unsigned i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_lvl_q <= db_lvl_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      move_q   <= move_d;
`ifdef NAV_AUTOREPEAT_EN
      timer_q  <= timer_d;
`endif
      for (int unsigned i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign kp.move_left  = move_q[0];
  assign kp.move_right = move_q[1];
  assign kp.move_up    = move_q[2];
  assign kp.move_down  = move_q[3];
  assign kp.held       = (state_q != IDLE);

endmodule

// File: tb/tb_nav_keypad.sv
// Directed-vector bench for nav_keypad (DEBOUNCE=4, DELAY=10, PERIOD=5) plus random pulse-shape monitor.
module tb_nav_keypad;

`ifdef NAV_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  int   viol = 0;
  int   pulses = 0;
  logic [3:0] prev_mv = '0;

  nav_keypad_if kp_if ();

  nav_keypad #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] b);
    kp_if.btn_left  = b[0];
    kp_if.btn_right = b[1];
    kp_if.btn_up    = b[2];
    kp_if.btn_down  = b[3];
  endtask

  // Pulse at 'first'; with auto-repeat, again at first+10, then every 5 while c < stop.
  function automatic bit train(input int c, input int first, input int stop);
    if (c == first) return 1'b1;
    return AR && (c >= first + 10) && (c < stop) && (((c - first - 10) % 5) == 0);
  endfunction

  function automatic logic [3:0] stim(input int id, input int c);
    case (id)
      0:       return 4'b0010;
      1:       return {1'b0, ((c >= 20) || (((c / 2) % 2) == 0)), 2'b00};
      2:       return {1'b1, 2'b00, (c < 12)};
      3:       return 4'b1000;
      default: return {3'b000, (c < 50)};
    endcase
  endfunction

  // Expected {held, down, up, right, left} in cycle c.
  function automatic logic [4:0] expv(input int id, input int c);
    logic l, r, u, d, h;
    l = 1'b0; r = 1'b0; u = 1'b0; d = 1'b0; h = 1'b0;
    case (id)
      0: begin r = train(c, 7, 30);  h = (c >= 7); end
      1: begin u = train(c, 27, 36); h = (c >= 27); end
      2: begin
        l = train(c, 7, 18);
        d = train(c, 20, 28);
        h = (c >= 7 && c <= 18) || (c >= 20);
      end
      3: begin
        d = train(c, 7, 13) || train(c, 20, 26);
        h = (c >= 7 && c <= 12) || (c >= 20);
      end
      default: begin l = train(c, 7, 57); h = (c >= 7 && c <= 56); end
    endcase
    return {h, d, u, r, l};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(4'b0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_case(input int id, input int n);
    logic [4:0] obs;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      obs = {kp_if.held, kp_if.move_down, kp_if.move_up, kp_if.move_right, kp_if.move_left};
      check($sformatf("case%0d_c%0d", id, c), 32'(obs), 32'(expv(id, c)));
      drive(stim(id, c));
      if (id == 3 && c == 12) reset = 1'b1;
      if (id == 3 && c == 13) reset = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] mv;
    mv = {kp_if.move_down, kp_if.move_up, kp_if.move_right, kp_if.move_left};
    if (mon_en) begin
      if (!$onehot0(mv))        viol   <= viol + 1;
      if ((mv & prev_mv) != 0)  viol   <= viol + 1;
      if (mv != 0)              pulses <= pulses + 1;
    end
    prev_mv <= mv;
  end

  initial begin
    int hold [4];
    logic [3:0] lvl;
    drive(4'b0000);
    run_case(0, 30);
    run_case(1, 36);
    run_case(2, 28);
    run_case(3, 26);
    run_case(4, 62);

    do_reset();
    lvl = '0;
    for (int b = 0; b < 4; b++) hold[b] = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 20));
        end else begin
          hold[b]--;
        end
      end
      drive(lvl);
    end
    @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    check("rand_shape_violations", 32'(viol), 32'd0);
    check("rand_saw_pulses", 32'(pulses > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
